// File: rtl/ram_loader_ctrl.sv
// Bus-mastering RAM loader: holds the control unit, then writes a word stream through MAR/MDR.
// Define RAM_LOADER_VERIFY_EN to compile in read-back verification (VREAD/VCHECK).
module ram_loader_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              one_shot_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    input  logic              cpu_idle,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] bus_drive,
    output logic              bus_drive_en,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mar_in,
    output logic              mdr_in,
    output logic              ram_write,
    output logic              ram_read,
    output logic              mdr_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              verify_err,
    output logic [ADDR_W:0]   words_written
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_BUS,
        ADDR,
        FETCH,
        DATA,
        WRITE,
        VREAD,
        VCHECK,
        FINISH
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx_q;
    logic [DATA_W-1:0] hold_q;
    logic [CNT_W-1:0]  words_written_q;
    logic              verify_err_q;
    logic              aborted_q;

    logic [CNT_W-1:0]  count_sat;
    logic [ADDR_W-1:0] cur_addr;
    logic              accept_start;
    logic              abort_taken;
    logic              last_word;
    logic              mismatch;

    // Counts above the RAM depth saturate so the loader never laps its own writes.
    assign count_sat    = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    assign cur_addr     = base_q + idx_q[ADDR_W-1:0];
    assign accept_start = (state == IDLE) && start && !abort;
    // FINISH has already presented done, so an abort there is not reported a second time.
    assign abort_taken  = abort && (state != IDLE) && (state != FINISH);

`ifdef RAM_LOADER_VERIFY_EN
    assign mismatch = (bus_in != hold_q);
`else
    logic unused_bus_in;
    assign unused_bus_in = ^bus_in;
    assign mismatch      = 1'b0;
`endif

    always_ff @(posedge one_shot_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        last_word  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept_start) begin
                    next_state = (count_sat == '0) ? FINISH : WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                if (cpu_idle) begin
                    next_state = ADDR;
                end
            end
            ADDR:  next_state = FETCH;
            FETCH: begin
                if (src_valid) begin
                    next_state = DATA;
                end
            end
            DATA:  next_state = WRITE;
            WRITE: begin
`ifdef RAM_LOADER_VERIFY_EN
                next_state = VREAD;
`else
                last_word  = ((idx_q + CNT_ONE) == count_q);
                next_state = last_word ? FINISH : ADDR;
`endif
            end
            VREAD: next_state = VCHECK;
            VCHECK: begin
                // idx has already advanced in WRITE, so compare it directly.
                last_word  = (idx_q == count_q);
                next_state = (mismatch || last_word) ? FINISH : ADDR;
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort_taken) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge one_shot_clock) begin
        if (reset) begin
            base_q          <= '0;
            count_q         <= '0;
            idx_q           <= '0;
            hold_q          <= '0;
            words_written_q <= '0;
            verify_err_q    <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            aborted_q <= abort_taken;
            if (accept_start) begin
                base_q          <= base_addr;
                count_q         <= count_sat;
                idx_q           <= '0;
                words_written_q <= '0;
                verify_err_q    <= 1'b0;
            end
            if ((state == FETCH) && src_valid && !abort) begin
                hold_q <= src_data;
            end
            // The write strobe is already on the bus this cycle, so it counts even under abort.
            if (state == WRITE) begin
                words_written_q <= words_written_q + CNT_ONE;
                idx_q           <= idx_q + CNT_ONE;
            end
            if ((state == VCHECK) && mismatch && !abort) begin
                verify_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        src_ready    = 1'b0;
        bus_drive    = '0;
        bus_drive_en = 1'b0;
        mar_in       = 1'b0;
        mdr_in       = 1'b0;
        ram_write    = 1'b0;
        ram_read     = 1'b0;
        mdr_out      = 1'b0;
        unique case (state)
            ADDR: begin
                bus_drive    = {{(DATA_W-ADDR_W){1'b0}}, cur_addr};
                bus_drive_en = 1'b1;
                mar_in       = 1'b1;
            end
            FETCH: src_ready = 1'b1;
            DATA: begin
                bus_drive    = hold_q;
                bus_drive_en = 1'b1;
                mdr_in       = 1'b1;
            end
            WRITE: ram_write = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
            VREAD:  ram_read = 1'b1;
            VCHECK: mdr_out  = 1'b1;
`endif
            default: begin
            end
        endcase
    end

    assign busy          = (state != IDLE);
    assign cpu_hold      = (state != IDLE);
    assign done          = (state == FINISH);
    assign aborted       = aborted_q;
    assign words_written = words_written_q;
`ifdef RAM_LOADER_VERIFY_EN
    assign verify_err    = verify_err_q;
`else
    assign verify_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader_ctrl.sv
// Scoreboard bench for ram_loader_ctrl with a behavioural MAR/MDR/RAM datapath around it.
// Build with RAM_LOADER_VERIFY_EN to exercise the read-back mismatch path.
module tb_ram_loader_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
`ifdef RAM_LOADER_VERIFY_EN
    localparam int WORD_CYC = 6;
`else
    localparam int WORD_CYC = 4;
`endif
    localparam int EV_DONE  = 1;
    localparam int EV_ABORT = 2;

    logic              one_shot_clock = 1'b0;
    logic              reset;
    logic              start, abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              cpu_idle;
    logic              cpu_hold;
    logic [DATA_W-1:0] bus_drive;
    logic              bus_drive_en;
    logic [DATA_W-1:0] bus_in;
    logic              mar_in, mdr_in, ram_write, ram_read, mdr_out;
    logic              busy, done, aborted, verify_err;
    logic [ADDR_W:0]   words_written;

    ram_loader_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .one_shot_clock(one_shot_clock), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count), .src_valid(src_valid),
        .src_data(src_data), .src_ready(src_ready), .cpu_idle(cpu_idle), .cpu_hold(cpu_hold),
        .bus_drive(bus_drive), .bus_drive_en(bus_drive_en), .bus_in(bus_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .ram_write(ram_write), .ram_read(ram_read),
        .mdr_out(mdr_out), .busy(busy), .done(done), .aborted(aborted),
        .verify_err(verify_err), .words_written(words_written)
    );

    always #5 one_shot_clock = ~one_shot_clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int  kind;
        int  ww;
        int  span;
        bit  lat;
    } ev_t;

    wr_t               write_q[$];
    ev_t               event_q[$];
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] load_words[$];

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;
    int first_mar    = -1;
    int last_write   = -1;
    int busy_chk_cyc = -1;
    bit hs_pending   = 1'b0;
    bit corrupt      = 1'b0;

    logic [ADDR_W-1:0] mar_m = '0;
    logic [DATA_W-1:0] mdr_m = '0;
    logic [DATA_W-1:0] ram_m [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] bus_val;

    // Behavioural datapath: one shared bus, MAR, MDR and the 256x16 RAM.
    assign bus_val = bus_drive_en ? bus_drive : (mdr_out ? mdr_m : '0);
    assign bus_in  = (corrupt && mdr_out && (mdr_m == 16'hBEEF)) ? '0 : bus_val;

    always @(posedge one_shot_clock) begin
        if (mar_in) mar_m <= bus_val[ADDR_W-1:0];
        if (mdr_in) mdr_m <= bus_val;
        else if (ram_read) mdr_m <= ram_m[mar_m];
        if (ram_write) ram_m[mar_m] <= mdr_m;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Source: a handshake seen at a falling edge completes on the following rising edge.
    always @(negedge one_shot_clock) begin
        if (reset) begin
            hs_pending = 1'b0;
        end else if (hs_pending && src_q.size() > 0) begin
            void'(src_q.pop_front());
        end
        src_valid  = (src_q.size() > 0);
        src_data   = (src_q.size() > 0) ? src_q[0] : '0;
        hs_pending = src_valid && src_ready && !reset;
    end

    // Monitor: pops the scoreboard whenever the DUT writes or reports completion.
    always @(negedge one_shot_clock) begin
        wr_t w;
        ev_t e;
        cyc++;
        if (!reset) begin
            if (mar_in && first_mar < 0) first_mar = cyc;
            if (mdr_out) checkOutput("bus_contention", {31'd0, bus_drive_en}, 32'd0);
            if (ram_write) begin
                if (write_q.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = write_q.pop_front();
                    checkOutput("write_addr", {24'd0, mar_m}, {24'd0, w.addr});
                    checkOutput("write_data", {16'd0, mdr_m}, {16'd0, w.data});
                end
                last_write = cyc;
            end
            if (done || aborted) begin
                if (event_q.size() == 0) begin
                    checkOutput("unexpected_event", {30'd0, aborted, done}, 32'd0);
                end else begin
                    e = event_q.pop_front();
                    checkOutput("event_kind", (done ? EV_DONE : EV_ABORT), e.kind);
                    checkOutput("words_written", {23'd0, words_written}, e.ww);
                    if (e.span >= 0) checkOutput("load_span", cyc - first_mar, e.span);
                    if (e.lat) begin
                        checkOutput("done_latency", cyc - last_write, 32'd1);
                        busy_chk_cyc = cyc + 1;
                    end
                end
            end
            if (cyc == busy_chk_cyc) checkOutput("busy_fall", {31'd0, busy}, 32'd0);
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count,
                                 input int nw, input int kind, input int ww,
                                 input int span, input bit lat);
        wr_t w;
        ev_t e;
        for (int i = 0; i < nw; i++) begin
            w.addr = base + ADDR_W'(i);
            w.data = load_words[i];
            write_q.push_back(w);
        end
        foreach (load_words[i]) src_q.push_back(load_words[i]);
        e.kind = kind; e.ww = ww; e.span = span; e.lat = lat;
        event_q.push_back(e);
        first_mar = -1;
        @(negedge one_shot_clock);
        start = 1'b1; base_addr = base; word_count = count;
        @(negedge one_shot_clock);
        start = 1'b0;
    endtask

    task automatic finishTest(input string name, input int limit);
        int n = 0;
        while (event_q.size() > 0 && n < limit) begin
            @(negedge one_shot_clock);
            n++;
        end
        if (event_q.size() > 0) begin
            checkOutput({name, "_timeout"}, 32'd1, 32'd0);
            event_q.delete();
        end
        checkOutput({name, "_leftover_writes"}, write_q.size(), 32'd0);
        write_q.delete();
        repeat (2) @(negedge one_shot_clock);
        src_q.delete();
        load_words.delete();
    endtask

    initial begin
        int acc;
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
        cpu_idle = 1'b1;
        repeat (3) @(negedge one_shot_clock);
        checkOutput("reset_status", {28'd0, busy, cpu_hold, done, aborted}, 32'd0);
        checkOutput("reset_bus", {15'd0, bus_drive_en, bus_drive}, 32'd0);
        checkOutput("reset_strobes", {26'd0, src_ready, mar_in, mdr_in, ram_write, ram_read, mdr_out}, 32'd0);
        checkOutput("reset_counts", {22'd0, verify_err, words_written}, 32'd0);
        reset = 1'b0;
        @(negedge one_shot_clock);

        $display("[TB] basic three-word load");
        load_words = {16'hAAAA, 16'h5555, 16'h1234};
        applyStimulus(8'h10, 9'd3, 3, EV_DONE, 3, 3*WORD_CYC, 1'b1);
        start = 1'b1; base_addr = 8'h77; word_count = 9'd9;
        @(negedge one_shot_clock);
        start = 1'b0;
        finishTest("basic", 200);
        checkOutput("ram_10", {16'd0, ram_m[8'h10]}, 32'hAAAA);
        checkOutput("ram_11", {16'd0, ram_m[8'h11]}, 32'h5555);
        checkOutput("ram_12", {16'd0, ram_m[8'h12]}, 32'h1234);
        checkOutput("ww_hold", {23'd0, words_written}, 32'd3);

        $display("[TB] bus wait for cpu_idle");
        cpu_idle = 1'b0;
        load_words = {16'hC0DE};
        applyStimulus(8'h30, 9'd1, 1, EV_DONE, 1, WORD_CYC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("wait_hold", {30'd0, cpu_hold, mar_in}, 32'd2);
            @(negedge one_shot_clock);
        end
        cpu_idle = 1'b1;
        @(negedge one_shot_clock);
        checkOutput("addr_after_idle", {15'd0, mar_in, bus_drive}, 32'h10030);
        finishTest("wait", 100);

        $display("[TB] address wrap");
        load_words = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        applyStimulus(8'hFE, 9'd4, 4, EV_DONE, 4, 4*WORD_CYC, 1'b1);
        finishTest("wrap", 200);

        $display("[TB] zero count");
        applyStimulus(8'h55, 9'd0, 0, EV_DONE, 0, -1, 1'b0);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc += int'(busy);
            checkOutput("zero_no_strobes", {29'd0, mar_in, mdr_in, ram_write}, 32'd0);
            @(negedge one_shot_clock);
        end
        checkOutput("zero_busy_cycles", acc, 32'd1);
        finishTest("zero", 20);

        $display("[TB] abort in second fetch");
        load_words = {16'h0101};
        applyStimulus(8'h20, 9'd5, 1, EV_ABORT, 1, -1, 1'b0);
        acc = 0;
        while (!(src_ready && words_written == 9'd1) && acc < 100) begin
            @(negedge one_shot_clock);
            acc++;
        end
        checkOutput("abort_reached_fetch", {31'd0, src_ready}, 32'd1);
        abort = 1'b1;
        @(negedge one_shot_clock);
        abort = 1'b0;
        checkOutput("abort_idle", {22'd0, busy, words_written}, 32'd1);
        finishTest("abort", 20);

        $display("[TB] start with abort in idle");
        start = 1'b1; abort = 1'b1; base_addr = 8'h60; word_count = 9'd2;
        @(negedge one_shot_clock);
        start = 1'b0; abort = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            acc += int'(busy);
            @(negedge one_shot_clock);
        end
        checkOutput("start_abort_idle", acc, 32'd0);

        $display("[TB] reset during load");
        src_q.push_back(16'h7777);
        start = 1'b1; base_addr = 8'h70; word_count = 9'd2;
        @(negedge one_shot_clock);
        start = 1'b0;
        repeat (2) @(negedge one_shot_clock);
        reset = 1'b1;
        @(negedge one_shot_clock);
        reset = 1'b0;
        checkOutput("reset_mid_load", {29'd0, busy, done, aborted}, 32'd0);
        @(negedge one_shot_clock);
        checkOutput("reset_mid_load_after", {29'd0, busy, done, aborted}, 32'd0);
        src_q.delete();

        $display("[TB] saturated count");
        for (int i = 0; i < 256; i++) load_words.push_back(16'(i) ^ 16'h5A00);
        applyStimulus(8'h80, 9'h1FF, 256, EV_DONE, 256, 256*WORD_CYC, 1'b1);
        finishTest("saturate", 2000);

`ifdef RAM_LOADER_VERIFY_EN
        $display("[TB] verify mismatch");
        corrupt = 1'b1;
        load_words = {16'h1111, 16'hBEEF, 16'h2222};
        applyStimulus(8'h40, 9'd3, 2, EV_DONE, 2, -1, 1'b0);
        finishTest("verify", 100);
        checkOutput("verify_err", {31'd0, verify_err}, 32'd1);
        corrupt = 1'b0;
`else
        checkOutput("verify_err_tied", {29'd0, verify_err, ram_read, mdr_out}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
